mantissa_divider_seq: RTL and testbench

- Iterative radix-2 restoring divider for normalized FPU mantissas. Produces one quotient bit per clock, plus a sticky bit for the rounding stage.
- Division counterpart of the multiplier mantissa datapath. Sits between operand unpack and the shared normalize/round stage.
- Start/Valid handshake. One division in flight at a time.

---
 rtl/fpu_div_pkg.sv | 14 +
 rtl/div_step.sv | 20 ++
 rtl/mantissa_divider_seq.sv | 119 +++++++++++
 tb/tb_mantissa_divider_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_div_pkg.sv
// Shared definitions for the mantissa divider datapath: default widths and FSM state encoding.
package fpu_div_pkg;

  localparam int unsigned MANT_W_DEF = 24;
  localparam int unsigned QBITS_DEF  = MANT_W_DEF + 2;
  localparam int unsigned CNT_W_DEF  = $clog2(QBITS_DEF);

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StDone
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: compare, conditionally subtract, shift left by one.
module div_step #(
  parameter int unsigned W = 24
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] div_i,
  output logic         qbit_o,
  output logic [W:0]   rem_o
);

  logic [W+1:0] diff;

  // R < 2D always holds, so R - D < D and the shifted result fits in W+1 bits.
  always_comb begin
    diff   = {1'b0, rem_i} - {2'b00, div_i};
    qbit_o = ~diff[W+1];
    rem_o  = qbit_o ? {diff[W-1:0], 1'b0} : {rem_i[W-1:0], 1'b0};
  end

endmodule

// File: rtl/mantissa_divider_seq.sv
// Sequential radix-2 restoring mantissa divider, one quotient bit per clock plus sticky.
// Define MANTISSA_DIV_EARLY_TERM_EN to finish as soon as the remainder reaches zero.
module mantissa_divider_seq
  import fpu_div_pkg::*;
#(
  parameter int unsigned MANT_W = MANT_W_DEF,
  parameter int unsigned QBITS  = MANT_W + 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [MANT_W-1:0] Dividend,
  input  logic [MANT_W-1:0] Divisor,
  output logic              Busy,
  output logic              Valid,
  output logic [QBITS-1:0]  Quotient,
  output logic              Sticky,
  output logic              DivByZero
);

  localparam int unsigned CntW = $clog2(QBITS);

  div_state_e        state_q;
  logic [MANT_W:0]   rem_q;
  logic [MANT_W-1:0] div_q;
  logic [CntW-1:0]   cnt_q;
  logic [QBITS-1:0]  quot_q;
  logic              busy_q;
  logic              valid_q;
  logic              sticky_q;
  logic              dbz_q;

  logic              qbit;
  logic [MANT_W:0]   rem_nxt;
  logic [QBITS-1:0]  quot_shift;

  div_step #(
    .W(MANT_W)
  ) u_div_step (
    .rem_i  (rem_q),
    .div_i  (div_q),
    .qbit_o (qbit),
    .rem_o  (rem_nxt)
  );

  assign quot_shift = {quot_q[QBITS-2:0], qbit};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      quot_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      sticky_q <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (Start) begin
            if (Divisor == '0) begin
              state_q  <= StDone;
              valid_q  <= 1'b1;
              dbz_q    <= 1'b1;
              quot_q   <= '1;
              sticky_q <= 1'b0;
            end else begin
              state_q  <= StIter;
              busy_q   <= 1'b1;
              rem_q    <= {1'b0, Dividend};
              div_q    <= Divisor;
              cnt_q    <= CntW'(QBITS - 1);
              quot_q   <= '0;
              dbz_q    <= 1'b0;
              sticky_q <= 1'b0;
            end
          end
        end
        StIter: begin
          rem_q  <= rem_nxt;
          quot_q <= quot_shift;
          cnt_q  <= cnt_q - CntW'(1);
`ifdef MANTISSA_DIV_EARLY_TERM_EN
          // Zero remainder: every remaining quotient bit is zero, so align and stop.
          if (rem_nxt == '0) begin
            quot_q   <= quot_shift << cnt_q;
            state_q  <= StDone;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
            sticky_q <= 1'b0;
          end else
`endif
          if (cnt_q == '0) begin
            state_q  <= StDone;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
            sticky_q <= (rem_nxt != '0);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign Busy      = busy_q;
  assign Valid     = valid_q;
  assign Quotient  = quot_q;
  assign Sticky    = sticky_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_mantissa_divider_seq.sv
// Scoreboard bench for mantissa_divider_seq: expected results are queued at Start and checked on Valid.
module tb_mantissa_divider_seq;

  localparam int unsigned MW = 24;
  localparam int unsigned QB = MW + 2;

  typedef struct {
    logic [QB-1:0] quot;
    logic          sticky;
    logic          dbz;
    int            lat;
    int            acc_edge;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   edges    = 0;

  logic          Clk      = 1'b0;
  logic          Reset    = 1'b1;
  logic          Start    = 1'b0;
  logic [MW-1:0] Dividend = '0;
  logic [MW-1:0] Divisor  = '0;
  logic          Busy;
  logic          Valid;
  logic [QB-1:0] Quotient;
  logic          Sticky;
  logic          DivByZero;

  mantissa_divider_seq #(
    .MANT_W(MW),
    .QBITS (QB)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Busy      (Busy),
    .Valid     (Valid),
    .Quotient  (Quotient),
    .Sticky    (Sticky),
    .DivByZero (DivByZero)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) edges <= edges + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Result monitor: every Valid pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    exp_t e;
    if (Valid === 1'b1) begin
      check_eq("valid_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("quotient", 64'(Quotient), 64'(e.quot));
        check_eq("sticky", 64'(Sticky), 64'(e.sticky));
        check_eq("divbyzero", 64'(DivByZero), 64'(e.dbz));
        check_eq("busy_at_valid", 64'(Busy), 64'd0);
        if (e.lat > 0) check_eq("latency", 64'(edges - e.acc_edge + 1), 64'(e.lat));
      end
    end
  end

  // Drive one Start pulse from a negedge; push the model result only if the DUT should accept.
  task automatic start_op(input logic [MW-1:0] a, input logic [MW-1:0] b, input bit push);
    exp_t            e;
    longint unsigned num;
    Dividend = a;
    Divisor  = b;
    Start    = 1'b1;
    if (push) begin
      num = 64'(a) << (QB - 1);
      if (b == '0) begin
        e.quot   = '1;
        e.sticky = 1'b0;
        e.dbz    = 1'b1;
        e.lat    = 1;
      end else begin
        e.quot   = QB'(num / 64'(b));
        e.sticky = ((num % 64'(b)) != 0);
        e.dbz    = 1'b0;
`ifdef MANTISSA_DIV_EARLY_TERM_EN
        e.lat    = 0;
`else
        e.lat    = QB + 1;
`endif
      end
      e.acc_edge = edges + 1;
      sb.push_back(e);
    end
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check_eq("drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
    @(negedge Clk);
  endtask

  initial begin
    logic [MW-1:0] ra;
    logic [MW-1:0] rb;

    repeat (2) @(negedge Clk);
    check_eq("rst_busy", 64'(Busy), 64'd0);
    check_eq("rst_valid", 64'(Valid), 64'd0);
    check_eq("rst_quot", 64'(Quotient), 64'd0);
    check_eq("rst_sticky", 64'(Sticky), 64'd0);
    check_eq("rst_dbz", 64'(DivByZero), 64'd0);
    Reset = 1'b0;
    @(negedge Clk);

    start_op(24'h800000, 24'h800000, 1'b1);
    wait_drain();
    start_op(24'hC00000, 24'h800000, 1'b1);
    wait_drain();
    start_op(24'h800000, 24'hC00000, 1'b1);
    wait_drain();
    start_op(24'hFFFFFF, 24'h800000, 1'b1);
    wait_drain();
    start_op(24'h800000, 24'hFFFFFF, 1'b1);
    wait_drain();

    // Divide by zero, then the result must hold while idle.
    start_op(24'h800000, 24'h000000, 1'b1);
    wait_drain();
    repeat (3) @(negedge Clk);
    check_eq("dbz_hold", 64'(DivByZero), 64'd1);
    check_eq("dbz_quot_hold", 64'(Quotient), 64'h3FFFFFF);

    // A second Start mid-division is dropped.
    start_op(24'hA00000, 24'hE00000, 1'b1);
    repeat (3) @(negedge Clk);
    check_eq("busy_mid", 64'(Busy), 64'd1);
    start_op(24'hFFFFFF, 24'h800001, 1'b0);
    wait_drain();

    // Reset mid-division aborts with no Valid pulse.
    start_op(24'hB00000, 24'h900000, 1'b0);
    repeat (8) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check_eq("abort_busy", 64'(Busy), 64'd0);
    check_eq("abort_valid", 64'(Valid), 64'd0);
    check_eq("abort_quot", 64'(Quotient), 64'd0);
    check_eq("abort_sticky", 64'(Sticky), 64'd0);
    check_eq("abort_dbz", 64'(DivByZero), 64'd0);
    repeat (40) @(negedge Clk);
    start_op(24'hC00000, 24'hA00000, 1'b1);
    wait_drain();

    for (int i = 0; i < 8; i++) begin
      ra = MW'($urandom);
      rb = MW'($urandom);
      ra[MW-1] = 1'b1;
      rb[MW-1] = 1'b1;
      start_op(ra, rb, 1'b1);
      wait_drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
